// File: rtl/f_le_server_if.sv
// f_le_server_if: compare request/response bus (req_valid/req_ready/a/b in, rsp_valid/res/err/busy out)
interface f_le_server_if #(parameter int FLEN = 64);
  logic req_valid, req_ready, rsp_valid, res, err, busy;
  logic [FLEN-1:0] a, b;
  modport master(output req_valid, a, b, input req_ready, rsp_valid, res, err, busy);
  modport slave(input req_valid, a, b, output req_ready, rsp_valid, res, err, busy);
endinterface

// File: rtl/f_le_server.sv
// f_le_server: sequential IEEE-754 a<=b comparator; ports clk, rst, s (slave: req_valid/a/b -> req_ready, rsp_valid, res, err, busy)
module f_le_server #(
  parameter int FLEN = 64,
  parameter int CHUNK = 16
) (
  input logic clk,
  input logic rst,
  f_le_server_if.slave s
);
  localparam int EXP_W = FLEN == 32 ? 8 : 11;
  localparam int NSLICE = (FLEN - 1 + CHUNK - 1) / CHUNK;
  localparam int MW = NSLICE * CHUNK;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);
  typedef enum logic [1:0] {IDLE, CLASSIFY, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [FLEN-1:0] ra, rb;
  logic [IW-1:0] idx, idx_n;
  logic res_q, res_n, err_q, err_n, load;
  logic [NSLICE-1:0][CHUNK-1:0] mag_a, mag_b;
  logic [CHUNK-1:0] sa, sb;
  logic special, zeros, neg;
  assign mag_a = MW'(ra[FLEN-2:0]);
  assign mag_b = MW'(rb[FLEN-2:0]);
  // slice 0 is the most-significant slice, stored at the top packed index
  assign sa = mag_a[LAST - idx];
  assign sb = mag_b[LAST - idx];
  assign special = (&ra[FLEN-2 -: EXP_W]) | (&rb[FLEN-2 -: EXP_W]);
  assign zeros = ~|ra[FLEN-2:0] & ~|rb[FLEN-2:0];
  assign neg = ra[FLEN-1];
  assign s.req_ready = state == IDLE;
  assign s.busy = state != IDLE;
  assign s.rsp_valid = state == DONE;
  assign s.res = res_q;
  assign s.err = err_q;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      res_q <= 1'b0;
      err_q <= 1'b0;
      ra <= '0;
      rb <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      res_q <= res_n;
      err_q <= err_n;
      ra <= load ? s.a : ra;
      rb <= load ? s.b : rb;
    end
  always_comb begin
    state_n = state;
    idx_n = idx;
    res_n = res_q;
    err_n = err_q;
    load = 1'b0;
    case (state)
      IDLE: if (s.req_valid) begin
        state_n = CLASSIFY;
        idx_n = '0;
        load = 1'b1;
      end
      CLASSIFY: begin
        state_n = special | zeros | (ra[FLEN-1] ^ rb[FLEN-1]) ? DONE : SCAN;
        err_n = special ? 1'b1 : err_q;
        res_n = special ? 1'b0 : zeros ? 1'b1 : ra[FLEN-1];
        err_n = state_n == DONE ? special : err_q;
        res_n = state_n == DONE ? res_n : res_q;
      end
      SCAN: if (sa != sb || idx == LAST) begin
        state_n = DONE;
        err_n = 1'b0;
        res_n = sa == sb ? 1'b1 : neg ? sa > sb : sa < sb;
      end else
        idx_n = idx + 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_f_le_server.sv
// tb_f_le_server: table-driven scoreboard bench for f_le_server
module tb_f_le_server;
  typedef struct {
    logic [63:0] a, b;
    logic res, err;
    int lat;
    int c0;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0, rsp_cnt = 0;
  vec_t sb[$];
  vec_t v[$];
  f_le_server_if #(.FLEN(64)) bus();
  f_le_server #(.FLEN(64), .CHUNK(16)) dut(.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (bus.rsp_valid) begin
      vec_t e;
      rsp_cnt++;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("res %h<=%h", e.a, e.b), 64'(bus.res), 64'(e.res));
        chk($sformatf("err %h<=%h", e.a, e.b), 64'(bus.err), 64'(e.err));
        chk($sformatf("lat %h<=%h", e.a, e.b), 64'(cyc - e.c0), 64'(e.lat));
      end
    end
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 64'(bus.req_ready), 64'd1);
  endtask
  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: got no response, expected one within 20 cycles");
      sb.delete();
    end
  endtask
  task automatic send(vec_t t);
    wait_ready();
    bus.a = t.a;
    bus.b = t.b;
    bus.req_valid = 1'b1;
    t.c0 = cyc;
    sb.push_back(t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_rsp();
  endtask
  initial begin
    vec_t t;
    int base;
    v.push_back('{64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 1'b0, 3, 0});
    v.push_back('{64'h4000000000000000, 64'h3FF0000000000000, 1'b0, 1'b0, 3, 0});
    v.push_back('{64'hC000000000000000, 64'hBFF0000000000000, 1'b1, 1'b0, 3, 0});
    v.push_back('{64'hBFF0000000000000, 64'hC000000000000000, 1'b0, 1'b0, 3, 0});
    v.push_back('{64'hBFF0000000000000, 64'h4000000000000000, 1'b1, 1'b0, 2, 0});
    v.push_back('{64'h3FF0000000000000, 64'h8000000000000000, 1'b0, 1'b0, 2, 0});
    v.push_back('{64'h400921FB54442D18, 64'h400921FB54442D18, 1'b1, 1'b0, 6, 0});
    v.push_back('{64'h3FF0000000000001, 64'h3FF0000000000000, 1'b0, 1'b0, 6, 0});
    v.push_back('{64'h3FF0000100000000, 64'h3FF0000000000000, 1'b0, 1'b0, 4, 0});
    v.push_back('{64'h3FF0000000000000, 64'h3FF0000000010000, 1'b1, 1'b0, 5, 0});
    v.push_back('{64'h7FF8000000000000, 64'h3FF0000000000000, 1'b0, 1'b1, 2, 0});
    v.push_back('{64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 1'b0, 3, 0});
    v.push_back('{64'h3FF0000000000000, 64'hFFF0000000000000, 1'b0, 1'b1, 2, 0});
    v.push_back('{64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, 1'b1, 2, 0});
    v.push_back('{64'h8000000000000000, 64'h0000000000000000, 1'b1, 1'b0, 2, 0});
    v.push_back('{64'h0000000000000000, 64'h8000000000000000, 1'b1, 1'b0, 2, 0});
    v.push_back('{64'h0000000000000000, 64'h3FF0000000000000, 1'b1, 1'b0, 3, 0});
    v.push_back('{64'h8000000000000000, 64'hBFF0000000000000, 1'b0, 1'b0, 3, 0});
    v.push_back('{64'h0000000000000001, 64'h0000000000000002, 1'b1, 1'b0, 6, 0});
    v.push_back('{64'h8000000000000002, 64'h8000000000000001, 1'b1, 1'b0, 6, 0});
    bus.req_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_res", 64'(bus.res), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (v[i]) send(v[i]);
    // requests strobed during cycles 1..4 of a full scan must be ignored
    wait_ready();
    base = rsp_cnt;
    t = '{64'h400921FB54442D18, 64'h400921FB54442D18, 1'b1, 1'b0, 6, cyc};
    bus.a = t.a;
    bus.b = t.b;
    bus.req_valid = 1'b1;
    sb.push_back(t);
    @(posedge clk); #1;
    bus.a = 64'h7FF8000000000000;
    chk("busy_c1", 64'(bus.busy), 64'd1);
    chk("ready_c1", 64'(bus.req_ready), 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    wait_rsp();
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("single_rsp", 64'(rsp_cnt - base), 64'd1);
    // reset in cycle 4 of a full scan aborts it; res was 1 beforehand
    wait_ready();
    base = rsp_cnt;
    bus.a = 64'h400921FB54442D18;
    bus.b = 64'h400921FB54442D18;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("scan_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_res", 64'(bus.res), 64'd0);
    chk("abort_err", 64'(bus.err), 64'd0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", 64'(rsp_cnt - base), 64'd0);
    // reset wins over a simultaneous request
    base = rsp_cnt;
    bus.a = 64'h3FF0000000000000;
    bus.b = 64'h4000000000000000;
    bus.req_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    chk("rst_req_busy", 64'(bus.busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("rst_req_no_rsp", 64'(rsp_cnt - base), 64'd0);
    send('{64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 1'b0, 3, 0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
